// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - 8-bit UART transmitter with parity, configurable stop bits and a one-entry holding buffer

module uart_tx #(
    parameter int BAUD_DIV  = 3,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       ready,
    output logic       busy,
    output logic       tx_done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
    localparam logic [2:0]  STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic        PAR_ODD   = (PARITY != 0);

    logic [2:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic        par_q, par_d;
    logic [7:0]  hold_q, hold_d;
    logic        full_q, full_d;
    logic        tx_q, tx_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        baud_end;
    logic        load;

    assign baud_end = (cnt_q == BAUD_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        hold_d  = hold_q;
        full_d  = full_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        load    = 1'b0;

        if (state_q != S_IDLE) begin
            cnt_d = baud_end ? 16'd0 : cnt_q + 16'd1;
        end

        case (state_q)
            S_IDLE: load = full_q;
            S_START: begin
                if (baud_end) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    if (bit_q == 3'd7) begin
                        state_d = S_PARITY;
                        tx_d    = par_q;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (baud_end) begin
                    state_d = S_STOP;
                    bit_d   = 3'd0;
                    tx_d    = 1'b1;
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    if (bit_q == STOP_LAST) begin
                        done_d = 1'b1;
                        if (full_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                tx_d    = 1'b1;
            end
        endcase

        // Loading the shifter frees the buffer; acceptance only happens when it is empty,
        // so the two can never coincide.
        if (load) begin
            state_d = S_START;
            cnt_d   = 16'd0;
            shift_d = hold_q;
            par_d   = (^hold_q) ^ PAR_ODD;
            full_d  = 1'b0;
            tx_d    = 1'b0;
            busy_d  = 1'b1;
        end

        if (tx_start && !full_q) begin
            hold_d = data_in;
            full_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'd0;
            par_q   <= 1'b0;
            hold_q  <= 8'd0;
            full_q  <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            hold_q  <= hold_d;
            full_q  <= full_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign tx_done = done_q;
    assign ready   = ~full_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx across three parameter sets

module tb_uart_tx;

    localparam int BD_T [3] = '{3, 4, 3};
    localparam int SB_T [3] = '{1, 2, 1};
    localparam int PO_T [3] = '{0, 0, 1};

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [2:0] tx_start = 3'b000;
    logic [7:0] data_in [3];
    logic [2:0] tx_w, ready_w, busy_w, tx_done_w;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [7:0]  exp_q [3][$];
    int          frames_seen [3];
    int          start_cyc [3];
    int          last_done [3];
    int          prev_done [3];
    int          spurious_done [3];
    logic [11:0] last_bits [3];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : gen_dut
        uart_tx #(.BAUD_DIV(BD_T[g]), .PARITY(PO_T[g]), .STOP_BITS(SB_T[g])) u_dut (
            .clk(clk), .reset(rst_n), .tx_start(tx_start[g]), .data_in(data_in[g]),
            .tx(tx_w[g]), .ready(ready_w[g]), .busy(busy_w[g]), .tx_done(tx_done_w[g])
        );
    end

    task automatic chk(input string name, input int g, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d got=%0h expected=%0h t=%0t", name, g, got, exp, $time);
        end
    endtask

    // Frame bit k of a byte: start, data LSB first, parity, then stop bits.
    function automatic logic frame_bit(input logic [7:0] d, input int k, input int po);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
        if (k == 9) return (^d) ^ (po != 0);
        return 1'b1;
    endfunction

    task automatic monitor(input int g);
        int bd, len;
        logic [7:0] eb;
        bit have, ok_w, ok_b, aborted, inframe;
        logic [11:0] bits;
        bd  = BD_T[g];
        len = (10 + SB_T[g]) * bd;
        forever begin
            @(negedge clk);
            if (tx_done_w[g]) spurious_done[g]++;
            inframe = rst_n && !tx_w[g];
            while (inframe) begin
                start_cyc[g] = cyc;
                have = (exp_q[g].size() != 0);
                eb = 8'h00;
                if (have) eb = exp_q[g].pop_front();
                ok_w = 1'b1; ok_b = 1'b1; aborted = 1'b0; bits = '1;
                for (int i = 0; i < len; i++) begin
                    if (i > 0) begin
                        @(negedge clk);
                        if (tx_done_w[g]) spurious_done[g]++;
                    end
                    if (!rst_n) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (tx_w[g] !== frame_bit(eb, i / bd, PO_T[g])) ok_w = 1'b0;
                    if (busy_w[g] !== 1'b1) ok_b = 1'b0;
                    if (i % bd == 0) bits[i / bd] = tx_w[g];
                end
                inframe = 1'b0;
                if (!aborted) begin
                    @(negedge clk);
                    chk("frame_expected", g, 32'(have), 32'd1);
                    if (have) begin
                        chk("frame_waveform", g, {23'd0, ok_w, eb}, {23'd0, 1'b1, eb});
                        chk("busy_in_frame", g, 32'(ok_b), 32'd1);
                    end
                    chk("tx_done_at_end", g, 32'(tx_done_w[g]), 32'd1);
                    prev_done[g]  = last_done[g];
                    last_done[g]  = cyc;
                    last_bits[g]  = bits;
                    frames_seen[g]++;
                    inframe = rst_n && !tx_w[g];
                end
            end
        end
    endtask

    task automatic send(input int g, input logic [7:0] b, output int acc);
        int n;
        n = 0;
        acc = -1;
        while (ready_w[g] !== 1'b1 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            chk("send_ready_timeout", g, 32'd0, 32'd1);
            return;
        end
        tx_start[g] = 1'b1;
        data_in[g]  = b;
        exp_q[g].push_back(b);
        @(posedge clk);
        @(negedge clk);
        acc = cyc;
        tx_start[g] = 1'b0;
        data_in[g]  = 8'($urandom);
        chk("ready_drop", g, 32'(ready_w[g]), 32'd0);
    endtask

    task automatic wait_frames(input int g, input int n);
        int k;
        k = 0;
        while (frames_seen[g] < n && k < 1000) begin
            @(negedge clk);
            k++;
        end
        if (k >= 1000) chk("frame_timeout", g, 32'(frames_seen[g]), 32'(n));
    endtask

    initial begin
        for (int g = 0; g < 3; g++) begin
            automatic int gg = g;
            fork
                monitor(gg);
            join_none
        end
    end

    initial begin : main
        int acc, acc0, f, bad, k, g;
        for (int i = 0; i < 3; i++) begin
            data_in[i] = 8'h00;
            frames_seen[i] = 0; spurious_done[i] = 0; last_done[i] = 0; prev_done[i] = 0;
            start_cyc[i] = 0; last_bits[i] = '1;
        end
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++)
            chk("reset_outputs", i, {28'd0, tx_w[i], ready_w[i], busy_w[i], tx_done_w[i]}, 32'hC);
        #2 rst_n = 1'b1;
        @(negedge clk);

        send(0, 8'hA5, acc);
        wait_frames(0, 1);
        chk("a5_bits", 0, 32'(last_bits[0][10:0]), 32'b10101001010);
        chk("start_latency", 0, 32'(start_cyc[0]), 32'(acc + 1));

        send(0, 8'h01, acc);
        wait_frames(0, 2);
        chk("even_parity_01", 0, 32'(last_bits[0][9]), 32'd1);
        send(2, 8'h01, acc);
        wait_frames(2, 1);
        chk("odd_parity_01", 2, 32'(last_bits[2][9]), 32'd0);
        send(2, 8'h00, acc);
        wait_frames(2, 2);
        chk("odd_parity_00", 2, 32'(last_bits[2][9]), 32'd1);

        send(1, 8'hC3, acc);
        wait_frames(1, 1);
        chk("c3_parity", 1, 32'(last_bits[1][9]), 32'd0);
        chk("c3_two_stops", 1, 32'(last_bits[1][11:10]), 32'd3);

        f = frames_seen[0];
        send(0, 8'h55, acc);
        send(0, 8'h0F, acc);
        tx_start[0] = 1'b1;
        data_in[0]  = 8'hFF;
        chk("ignored_write_ready", 0, 32'(ready_w[0]), 32'd0);
        @(posedge clk);
        @(negedge clk);
        tx_start[0] = 1'b0;
        wait_frames(0, f + 2);
        chk("b2b_done_spacing", 0, 32'(last_done[0] - prev_done[0]), 32'd33);

        repeat (5) @(negedge clk);
        send(0, 8'h00, acc0);
        send(0, 8'h33, acc);
        while (cyc < acc0 + 1 + 16) @(negedge clk);
        chk("bit4_low_before_reset", 0, 32'(tx_w[0]), 32'd0);
        #2 rst_n = 1'b0;
        #1 chk("reset_async_tx", 0, 32'(tx_w[0]), 32'd1);
        repeat (3) @(negedge clk);
        exp_q[0].delete();
        #2 rst_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk("ready_after_reset", i, 32'(ready_w[i]), 32'd1);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (tx_w[0] !== 1'b1 || tx_done_w[0] !== 1'b0) bad++;
            data_in[0] = 8'($urandom);
            @(negedge clk);
        end
        chk("post_reset_idle", 0, 32'(bad), 32'd0);

        for (int r = 0; r < 24; r++) begin
            g = int'($urandom_range(0, 2));
            send(g, 8'($urandom), acc);
            k = int'($urandom_range(0, 40));
            for (int j = 0; j < k; j++) begin
                data_in[g] = 8'($urandom);
                @(negedge clk);
            end
        end

        k = 0;
        while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() != 0 || busy_w != 3'b000) && k < 3000) begin
            @(negedge clk);
            k++;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("queue_drained", i, 32'(exp_q[i].size()), 32'd0);
            chk("no_spurious_done", i, 32'(spurious_done[i]), 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
